// File: rtl/bus_master_rr.sv
`timescale 1ns/1ps
// Round-robin arbitrated req/ack bus master; 1-cycle request-to-bus, all outputs registered.
// Four-phase handshake: holds RELEASE until ack drops; optional timeout aborts a stalled transfer.
module bus_master_rr #(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 2,
  parameter int TIMEOUT = 15,
  parameter int ID_W    = $clog2(N_CH)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_CH-1:0]        req_in,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic                   ack,
  output logic                   req_out,
  output logic [DATA_W-1:0]      data_out,
  output logic                   bus_en,
  output logic [ID_W-1:0]        grant_id,
  output logic [N_CH-1:0]        done,
  output logic [N_CH-1:0]        err
);

  typedef enum logic [1:0] {IDLE, REQ, RELEASE} state_t;

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(N_CH - 1);

  state_t            state, state_nxt;
  logic [ID_W-1:0]   last_grant, last_nxt, id_nxt, pick, idx;
  logic              pick_vld;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              req_nxt, en_nxt;
  logic [DATA_W-1:0] data_nxt;
  logic [N_CH-1:0]   done_nxt, err_nxt;
  logic [DATA_W-1:0] ch_dat [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign ch_dat[i] = data_in[i*DATA_W +: DATA_W];
  end

  // First requester strictly after last_grant, wrapping around.
  always_comb begin
    pick_vld = 1'b0;
    pick     = '0;
    idx      = '0;
    for (int k = 1; k <= N_CH; k++) begin
      idx = ID_W'((int'(last_grant) + k) % N_CH);
      if (!pick_vld && req_in[idx]) begin
        pick_vld = 1'b1;
        pick     = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last_grant;
    cnt_nxt   = cnt;
    req_nxt   = req_out;
    en_nxt    = bus_en;
    data_nxt  = data_out;
    id_nxt    = grant_id;
    done_nxt  = '0;
    err_nxt   = '0;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt = REQ;
          last_nxt  = pick;
          id_nxt    = pick;
          data_nxt  = ch_dat[pick];
          req_nxt   = 1'b1;
          en_nxt    = 1'b1;
          cnt_nxt   = '0;
        end
      end
      REQ: begin
        if (ack) begin
          done_nxt[grant_id] = 1'b1;
          state_nxt = RELEASE;
          req_nxt   = 1'b0;
          en_nxt    = 1'b0;
          data_nxt  = '0;
        end else if ((TIMEOUT != 0) && (cnt == CNT_END)) begin
          err_nxt[grant_id] = 1'b1;
          state_nxt = RELEASE;
          req_nxt   = 1'b0;
          en_nxt    = 1'b0;
          data_nxt  = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      RELEASE: begin
        if (!ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= LAST_RST;
      cnt        <= '0;
      req_out    <= 1'b0;
      bus_en     <= 1'b0;
      data_out   <= '0;
      grant_id   <= '0;
      done       <= '0;
      err        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_nxt;
      cnt        <= cnt_nxt;
      req_out    <= req_nxt;
      bus_en     <= en_nxt;
      data_out   <= data_nxt;
      grant_id   <= id_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_bus_master_rr.sv
`timescale 1ns/1ps
// Bench for bus_master_rr: expected grants queued at stimulus time, checked when req_out rises.
module tb_bus_master_rr;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req_in = '0;
  logic [3:0] req_in0 = '0;
  logic [7:0] data_in = '0;
  logic       ack = 1'b0;

  logic       req_out, bus_en;
  logic [1:0] data_out, grant_id;
  logic [3:0] done, err;

  logic       req_out_z, bus_en_z;
  logic [1:0] data_out_z, grant_id_z;
  logic [3:0] done_z, err_z;

  typedef struct packed {
    logic [1:0] id;
    logic [1:0] dat;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;

  bus_master_rr dut (
    .clk(clk), .reset(reset), .req_in(req_in), .data_in(data_in), .ack(ack),
    .req_out(req_out), .data_out(data_out), .bus_en(bus_en),
    .grant_id(grant_id), .done(done), .err(err)
  );

  bus_master_rr #(.TIMEOUT(0)) dut0 (
    .clk(clk), .reset(reset), .req_in(req_in0), .data_in(data_in), .ack(ack),
    .req_out(req_out_z), .data_out(data_out_z), .bus_en(bus_en_z),
    .grant_id(grant_id_z), .done(done_z), .err(err_z)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Waits for req_out of the main DUT, then pops and compares the queued grant.
  task automatic wait_grant(input string name);
    exp_t e;
    for (int w = 0; w < 12 && !req_out; w++) @(negedge clk);
    total++;
    if (req_out !== 1'b1) begin
      bad++;
      $display("FAIL %s_no_grant req_out=%b want 1", name, req_out);
    end
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s_sb_empty queue size=0 want >0", name);
    end else begin
      e = sb.pop_front();
      if ({grant_id, data_out, bus_en} !== {e.id, e.dat, 1'b1}) begin
        bad++;
        $display("FAIL %s_grant id=%0d dat=%b en=%b want id=%0d dat=%b en=1",
                 name, grant_id, data_out, bus_en, e.id, e.dat);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({req_out, bus_en, data_out, grant_id, done, err} !== 13'd0) begin
      bad++;
      $display("FAIL reset_outputs got=%b want 0", {req_out, bus_en, data_out, grant_id, done, err});
    end
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (req_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle req_out=%b want 0", req_out);
    end
  endtask

  task automatic test_single();
    exp_t e;
    data_in = 8'b0011_0000;
    req_in  = 4'b0100;
    sb.push_back('{id: 2'd2, dat: 2'b11});
    @(negedge clk);
    total++;
    if (req_out !== 1'b1) begin
      bad++;
      $display("FAIL single_latency req_out=%b want 1", req_out);
    end
    e = sb.pop_front();
    total++;
    if ({grant_id, data_out, bus_en} !== {e.id, e.dat, 1'b1}) begin
      bad++;
      $display("FAIL single_grant id=%0d dat=%b en=%b want id=%0d dat=%b en=1",
               grant_id, data_out, bus_en, e.id, e.dat);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({req_out, bus_en, data_out, done} !== {1'b1, 1'b1, 2'b11, 4'b0000}) begin
        bad++;
        $display("FAIL single_hold req=%b en=%b dat=%b done=%b want 1 1 11 0000",
                 req_out, bus_en, data_out, done);
      end
    end
    ack = 1'b1;
    @(negedge clk);
    total++;
    if ({done, err, req_out, bus_en, data_out} !== {4'b0100, 4'b0000, 1'b0, 1'b0, 2'b00}) begin
      bad++;
      $display("FAIL single_done done=%b err=%b req=%b en=%b dat=%b want 0100 0000 0 0 00",
               done, err, req_out, bus_en, data_out);
    end
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if ({done, req_out} !== 5'b0000_0) begin
        bad++;
        $display("FAIL single_release done=%b req=%b want 0000 0", done, req_out);
      end
    end
    ack = 1'b0;
    req_in = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_round_robin();
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    data_in = 8'b11_10_01_00;
    req_in  = 4'b1111;
    sb.push_back('{id: 2'd0, dat: 2'd0});
    sb.push_back('{id: 2'd1, dat: 2'd1});
    sb.push_back('{id: 2'd2, dat: 2'd2});
    sb.push_back('{id: 2'd3, dat: 2'd3});
    sb.push_back('{id: 2'd0, dat: 2'd0});
    for (int t = 0; t < 6; t++) begin
      logic [1:0] gid;
      wait_grant("rr");
      gid = grant_id;
      @(negedge clk);
      ack = 1'b1;
      @(negedge clk);
      total++;
      if (done !== (4'b0001 << gid)) begin
        bad++;
        $display("FAIL rr_done t=%0d done=%b want %b", t, done, 4'b0001 << gid);
      end
      if (t == 4) begin
        req_in = 4'b1001;
        sb.push_back('{id: 2'd3, dat: 2'd3});
      end
      if (t == 5) req_in = 4'b0000;
      ack = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_timeout();
    int hi;
    data_in = 8'b11_10_01_00;
    req_in  = 4'b0010;
    sb.push_back('{id: 2'd1, dat: 2'd1});
    wait_grant("timeout");
    req_in = 4'b0000;
    hi = 0;
    while (req_out === 1'b1 && hi < 40) begin
      hi++;
      @(negedge clk);
    end
    total++;
    if (hi != 15) begin
      bad++;
      $display("FAIL timeout_len req_out high=%0d cycles want 15", hi);
    end
    total++;
    if ({err, done, req_out} !== {4'b0010, 4'b0000, 1'b0}) begin
      bad++;
      $display("FAIL timeout_err err=%b done=%b req=%b want 0010 0000 0", err, done, req_out);
    end
    @(negedge clk);
    total++;
    if ({err, req_out} !== 5'b0000_0) begin
      bad++;
      $display("FAIL timeout_pulse err=%b req=%b want 0000 0", err, req_out);
    end
    @(negedge clk);
  endtask

  task automatic test_collision();
    data_in = 8'b11_10_01_10;
    req_in  = 4'b0001;
    sb.push_back('{id: 2'd0, dat: 2'b10});
    wait_grant("collision");
    repeat (14) @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    total++;
    if ({done, err} !== {4'b0001, 4'b0000}) begin
      bad++;
      $display("FAIL collision done=%b err=%b want 0001 0000", done, err);
    end
    ack = 1'b0;
    req_in = 4'b0000;
    @(negedge clk);
    total++;
    if (err !== 4'b0000) begin
      bad++;
      $display("FAIL collision_err_late err=%b want 0000", err);
    end
    @(negedge clk);
  endtask

  task automatic test_data_stable();
    data_in = 8'b10_00_00_00;
    req_in  = 4'b1000;
    sb.push_back('{id: 2'd3, dat: 2'b10});
    wait_grant("stable");
    data_in = 8'hFF;
    req_in  = 4'b0000;
    repeat (2) @(negedge clk);
    total++;
    if ({req_out, bus_en, data_out, grant_id} !== {1'b1, 1'b1, 2'b10, 2'd3}) begin
      bad++;
      $display("FAIL stable_hold req=%b en=%b dat=%b id=%0d want 1 1 10 3",
               req_out, bus_en, data_out, grant_id);
    end
    ack = 1'b1;
    @(negedge clk);
    total++;
    if (done !== 4'b1000) begin
      bad++;
      $display("FAIL stable_done done=%b want 1000", done);
    end
    ack = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_async_reset();
    data_in = 8'b11_11_11_01;
    req_in  = 4'b0100;
    sb.push_back('{id: 2'd2, dat: 2'b11});
    wait_grant("areset");
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    total++;
    if ({req_out, bus_en, data_out, grant_id, done, err} !== 13'd0) begin
      bad++;
      $display("FAIL areset_outputs got=%b want 0", {req_out, bus_en, data_out, grant_id, done, err});
    end
    @(negedge clk);
    total++;
    if ({done, err} !== 8'd0) begin
      bad++;
      $display("FAIL areset_pulse done=%b err=%b want 0000 0000", done, err);
    end
    req_in = 4'b1111;
    reset  = 1'b1;
    sb.push_back('{id: 2'd0, dat: 2'b01});
    wait_grant("areset_first");
    ack = 1'b1;
    @(negedge clk);
    total++;
    if (done !== 4'b0001) begin
      bad++;
      $display("FAIL areset_done done=%b want 0001", done);
    end
    ack = 1'b0;
    req_in = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_no_timeout();
    int low;
    data_in = 8'b00_00_00_11;
    req_in0 = 4'b0001;
    for (int w = 0; w < 12 && !req_out_z; w++) @(negedge clk);
    total++;
    if ({req_out_z, bus_en_z, grant_id_z, data_out_z} !== {1'b1, 1'b1, 2'd0, 2'b11}) begin
      bad++;
      $display("FAIL notimeout_grant req=%b en=%b id=%0d dat=%b want 1 1 0 11",
               req_out_z, bus_en_z, grant_id_z, data_out_z);
    end
    low = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (req_out_z !== 1'b1 || err_z !== 4'b0000) low++;
    end
    total++;
    if (low != 0) begin
      bad++;
      $display("FAIL notimeout_hold dropped_or_err cycles=%0d want 0", low);
    end
    ack = 1'b1;
    @(negedge clk);
    total++;
    if (done_z !== 4'b0001) begin
      bad++;
      $display("FAIL notimeout_done done=%b want 0001", done_z);
    end
    ack = 1'b0;
    req_in0 = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_collision();
    test_data_stable();
    test_async_reset();
    test_no_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_master_rr.md
# bus_master_rr

Parametrised multi-channel bus master. It accepts requests from `N_CH` local requesters and arbitrates among them round-robin. It drives a single req/ack bus with the winning channel's data, and it reports completion or timeout back to that channel. It sits between the local requesters and the shared bus slave. It replaces the single-channel master, which passed data straight through, with registered, arbitrated, timeout-protected transfers.

## Interface

Parameters:
- `N_CH`, 4 — number of requester channels (≥2).
- `DATA_W`, 2 — data width per channel.
- `TIMEOUT`, 15 — cycles `req_out` stays high without `ack` before abort; 0 disables the timeout.
- `ID_W`, `$clog2(N_CH)` — derived, width of `grant_id`.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `reset`  in  1  — asynchronous, active-low (block in reset while 0).
- `req_in`  in  `N_CH`  — per-channel request level.
- `data_in`  in  `N_CH*DATA_W`  — channel i data at bits `[i*DATA_W +: DATA_W]`.
- `ack`  in  1  — slave acknowledge.
- `req_out`  out  1  — bus request, registered.
- `data_out`  out  `DATA_W`  — bus data, registered; 0 when `bus_en`=0 (no tristate).
- `bus_en`  out  1  — `data_out` valid/driven.
- `grant_id`  out  `ID_W`  — channel currently owning the bus.
- `done`  out  `N_CH`  — one-cycle pulse per channel on a successful transfer.
- `err`  out  `N_CH`  — one-cycle pulse per channel on a timeout abort.

## Operation

- All outputs are registered.
- Reset values: `req_out`=0, `bus_en`=0, `data_out`=0, `grant_id`=0, `done`=0, `err`=0, state=IDLE, internal `last_grant`=`N_CH-1` (so channel 0 has first priority), timeout counter=0.
- FSM states: IDLE, REQ, RELEASE.
- IDLE:
  - If any `req_in` bit is 1, select the first set bit scanning upward from `last_grant+1` (mod `N_CH`).
  - Latch that channel's `data_in`, set `grant_id` and `last_grant` to it, and go to REQ with `req_out`=1 and `bus_en`=1.
  - No request: stay in IDLE.
- REQ:
  - `data_out` holds the latched data. Changes on `data_in`/`req_in` are ignored.
  - `ack`=1: pulse `done[grant_id]` and go to RELEASE.
  - Else, if `TIMEOUT`≠0 and the counter equals `TIMEOUT-1`: pulse `err[grant_id]` and go to RELEASE.
  - Else: increment the counter.
  - The counter clears on entry to REQ. It is wide enough for `TIMEOUT` and never wraps.
- RELEASE:
  - `req_out`=0, `bus_en`=0, `data_out`=0.
  - Stay until `ack`=0 (four-phase handshake), then go to IDLE.
- Priority rules:
  - `ack` wins over timeout on the same edge.
  - A requester dropping `req_in` during REQ does not cancel the transfer.
- Reset asserted mid-transfer: all outputs return immediately to their reset values, with no `done`/`err` pulse. The arbitration pointer is reset.

## Timing

- Request to bus: `req_in` high at edge E0 in IDLE → `req_out`/`bus_en`/`data_out`/`grant_id` valid after E0 (1-cycle latency).
- Completion:
  - `ack` sampled high at edge E1 → `done` high for exactly the cycle after E1.
  - `req_out` falls after E1.
- Timeout: `req_out` high for exactly `TIMEOUT` cycles with `ack`=0 → `err` pulse in the following cycle, with `req_out` low at the same time.
- Minimum turnaround: REQ, RELEASE (≥1 cycle), IDLE (1 cycle), next REQ. So `req_out` is low for ≥2 cycles between transfers.
- `ack` already high when entering REQ completes the transfer at the first REQ edge (1-cycle `req_out` pulse).
- Fairness: with all channels requesting continuously, grants rotate 0,1,2,…,`N_CH-1`,0.

## Test plan

- Single request: defaults, `req_in`=4'b0100, `data_in[5:4]`=2'b11, `ack` raised 3 cycles after `req_out` → `grant_id`=2, `data_out`=2'b11 and `bus_en`=1 while `req_out`=1, `done`=4'b0100 for one cycle, `req_out` low after `ack`, RELEASE held until `ack`=0.
- Round-robin: `req_in`=4'b1111 held, slave acks 1 cycle after each `req_out` → grant order 0,1,2,3,0. Then `req_in`=4'b1001 with `last_grant`=0 → next grant is 3.
- Timeout: `TIMEOUT`=15, `ack` held 0 → `req_out` high exactly 15 cycles, then `err[grant_id]` for one cycle, `done`=0, FSM returns to IDLE.
- Ack/timeout collision: `ack` rises on the same edge the counter reaches 14 → `done` pulses, `err` stays 0. With `TIMEOUT`=0 and no `ack` → `req_out` stays high indefinitely.
- Async reset mid-REQ: assert `reset`=0 between clock edges → `req_out`, `bus_en`, `data_out`, `grant_id`, `done`, `err` go to 0 before the next edge. After release, the first grant with `req_in`=4'b1111 is channel 0.
- Data stability: `data_in` of the granted channel changes, and its `req_in` drops, during REQ → `data_out` unchanged and the transfer completes with `done`.
